// File: rtl/axi_wr_sched.sv
// Write-channel scheduler for an N-to-1 AXI write path: round-robin AW arbitration with the
// grant locked across AW, all W beats and B; checks WLAST against AWLEN and times out on B.
module axi_wr_sched #(
  parameter int SLAVE_NUM = 2,
  parameter int LEN_WIDTH = 8,
  parameter int TIMEOUT   = 1024,
  localparam int IDX_W    = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [SLAVE_NUM-1:0]           s_awvalid,
  input  logic [LEN_WIDTH*SLAVE_NUM-1:0] s_awlen,
  input  logic                           m_awready,
  input  logic                           m_wvalid,
  input  logic                           m_wready,
  input  logic                           m_wlast,
  input  logic                           m_bvalid,
  input  logic                           m_bready,
  output logic [IDX_W-1:0]               grant_idx,
  output logic [SLAVE_NUM-1:0]           grant_oh,
  output logic                           aw_en,
  output logic                           w_en,
  output logic                           b_en,
  output logic                           busy,
  output logic                           err_wlast,
  output logic                           err_timeout,
  output logic [1:0]                     dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid and ready are both high while the
  // matching enable is set; valid never depends on ready.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2, S_RESP = 2'd3} state_e;

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SLAVE_NUM - 1);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]     last_grant_q, last_grant_d;
  logic [SLAVE_NUM-1:0] grant_oh_q, grant_oh_d;
  logic [LEN_WIDTH-1:0] beat_left_q, beat_left_d;
  logic                 wdone_q, wdone_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [IDX_W-1:0]     pick_idx, scan_idx;
  logic [SLAVE_NUM-1:0] pick_oh;
  logic [LEN_WIDTH-1:0] pick_len;
  logic                 pick_found;
  logic                 aw_hs, w_hs, b_hs, last_beat, w_done, timeout_hit;

  // Scan starts one past the last winner and wraps, so every requester gets a turn.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    scan_idx   = (last_grant_q == IDX_LAST) ? '0 : last_grant_q + 1'b1;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      if (!pick_found && s_awvalid[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
      scan_idx = (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
    pick_len          = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      if (pick_idx == IDX_W'(i)) pick_len = s_awlen[i*LEN_WIDTH +: LEN_WIDTH];
    end
  end

  assign aw_en       = (state_q == S_ADDR);
  assign w_en        = ((state_q == S_ADDR) && !wdone_q) || (state_q == S_DATA);
  assign b_en        = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign grant_idx   = grant_idx_q;
  assign grant_oh    = grant_oh_q;
  assign dbg_state   = state_q;

  assign aw_hs       = aw_en & m_awready & s_awvalid[grant_idx_q];
  assign w_hs        = w_en & m_wvalid & m_wready;
  assign b_hs        = b_en & m_bvalid & m_bready;
  assign last_beat   = (beat_left_q == '0);
  // The burst ends at the first of WLAST or the counted last beat; a disagreement is flagged.
  assign w_done      = w_hs & (m_wlast | last_beat);
  assign err_wlast   = w_done & (m_wlast != last_beat);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d      = state_q;
    grant_idx_d  = grant_idx_q;
    grant_oh_d   = grant_oh_q;
    last_grant_d = last_grant_q;
    beat_left_d  = beat_left_q;
    wdone_d      = wdone_q;
    cnt_d        = '0;
    err_timeout  = 1'b0;
    if (w_hs && !last_beat) beat_left_d = beat_left_q - 1'b1;
    if (w_done) wdone_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d     = S_ADDR;
          grant_idx_d = pick_idx;
          grant_oh_d  = pick_oh;
          beat_left_d = pick_len;
          wdone_d     = 1'b0;
        end
      end
      S_ADDR: begin
        if (aw_hs) state_d = (wdone_q || w_done) ? S_RESP : S_DATA;
      end
      S_DATA: begin
        if (w_done) state_d = S_RESP;
      end
      S_RESP: begin
        cnt_d = cnt_q + 1'b1;
        if (b_hs || timeout_hit) begin
          err_timeout  = !b_hs;
          last_grant_d = grant_idx_q;
          grant_oh_d   = '0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q      <= S_IDLE;
      grant_idx_q  <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= IDX_LAST;
      beat_left_q  <= '0;
      wdone_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      grant_oh_q   <= grant_oh_d;
      last_grant_q <= last_grant_d;
      beat_left_q  <= beat_left_d;
      wdone_q      <= wdone_d;
      cnt_q        <= cnt_d;
    end
  end

endmodule

// File: tb/tb_axi_wr_sched.sv
// Self-checking bench for axi_wr_sched: reset, round-robin, W-before-AW, WLAST checks,
// B timeout and back-to-back grants, with expected grants/flags held in a scoreboard queue.
module tb_axi_wr_sched;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  logic        aclk;
  logic        areset;
  logic [1:0]  s_awvalid;
  logic [15:0] s_awlen;
  logic        m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
  logic [0:0]  grant_idx;
  logic [1:0]  grant_oh;
  logic        aw_en, w_en, b_en, busy, err_wlast, err_timeout;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [0:0] exp_q[$];

  axi_wr_sched #(.SLAVE_NUM(2), .LEN_WIDTH(8), .TIMEOUT(16)) dut (
    .aclk(aclk), .areset(areset), .s_awvalid(s_awvalid), .s_awlen(s_awlen),
    .m_awready(m_awready), .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .grant_idx(grant_idx), .grant_oh(grant_oh),
    .aw_en(aw_en), .w_en(w_en), .b_en(b_en), .busy(busy), .err_wlast(err_wlast),
    .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run still active at %0t, limit 100000", $time);
    $fatal(1);
  end

  // ---------------- drivers ----------------
  task automatic clear_inputs();
    s_awvalid = 2'b00; s_awlen = 16'h0;
    m_awready = 1'b0; m_wvalid = 1'b0; m_wready = 1'b0; m_wlast = 1'b0;
    m_bvalid = 1'b0; m_bready = 1'b0;
  endtask

  task automatic wait_state(input logic [1:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge aclk); #1;
      if (dbg_state == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    areset = 1'b1;
    clear_inputs();
    @(negedge aclk); #1;
    n_tests++; if (grant_oh !== 2'b00) begin n_fail++; $display("FAIL reset_grant_oh: got %b expected 00", grant_oh); end
    n_tests++; if (grant_idx !== 1'b0) begin n_fail++; $display("FAIL reset_grant_idx: got %b expected 0", grant_idx); end
    n_tests++; if ({aw_en, w_en, b_en} !== 3'b000) begin n_fail++; $display("FAIL reset_enables: got %b expected 000", {aw_en, w_en, b_en}); end
    n_tests++; if ({busy, err_wlast, err_timeout} !== 3'b000) begin n_fail++; $display("FAIL reset_busy_err: got %b expected 000", {busy, err_wlast, err_timeout}); end
    areset = 1'b0;
  endtask

  task automatic test_reset_mid_data();
    bit ok;
    logic [0:0] e;
    clear_inputs();
    s_awlen = {8'd3, 8'd3}; s_awvalid = 2'b01;
    m_awready = 1'b1; m_wvalid = 1'b1; m_wready = 1'b1; m_bready = 1'b1;
    wait_state(ST_DATA, 20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL t1_reach_data: state %0d expected %0d", dbg_state, ST_DATA); end
    #2 areset = 1'b1;
    #1;
    n_tests++; if (grant_oh !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL t1_async_clear: grant_oh=%b busy=%b expected 00/0", grant_oh, busy); end
    n_tests++; if ({aw_en, w_en, b_en} !== 3'b000) begin n_fail++; $display("FAIL t1_async_enables: got %b expected 000", {aw_en, w_en, b_en}); end
    @(negedge aclk);
    areset = 1'b0;
    s_awvalid = 2'b11; s_awlen = 16'h0; m_wlast = 1'b1; m_bvalid = 1'b1;
    exp_q.push_back(1'b0);
    wait_state(ST_ADDR, 20, ok);
    e = exp_q.pop_front();
    n_tests++; if (!ok || grant_idx !== e || grant_oh !== (2'b01 << e)) begin n_fail++; $display("FAIL t1_first_after_reset: grant_idx=%b grant_oh=%b expected %b/%b", grant_idx, grant_oh, e, 2'b01 << e); end
    @(negedge aclk); #1;
    s_awvalid = 2'b00;
    wait_state(ST_IDLE, 20, ok);
  endtask

  task automatic test_rr_fairness();
    int beats, done;
    logic prev_aw;
    bit err_seen, ok;
    logic [0:0] e;
    clear_inputs();
    areset = 1'b1;
    @(negedge aclk); #1;
    areset = 1'b0;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    s_awlen = {8'd3, 8'd3}; s_awvalid = 2'b11;
    m_awready = 1'b1; m_wvalid = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bready = 1'b1;
    beats = 0; done = 0; prev_aw = 1'b0; err_seen = 1'b0;
    for (int c = 0; c < 100 && done < 4; c++) begin
      m_wlast = (beats == 3);
      #1;
      if (aw_en && !prev_aw) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rr_extra_grant: grant_idx=%b, expected no further grant", grant_idx);
        end else begin
          e = exp_q.pop_front();
          if (grant_idx !== e || grant_oh !== (2'b01 << e)) begin n_fail++; $display("FAIL rr_grant: grant_idx=%b grant_oh=%b expected %b/%b", grant_idx, grant_oh, e, 2'b01 << e); end
        end
      end
      prev_aw = aw_en;
      if (err_wlast || err_timeout) err_seen = 1'b1;
      if (w_en) beats++;
      if (b_en) begin
        n_tests++; if (beats != 4) begin n_fail++; $display("FAIL rr_beats: got %0d expected 4", beats); end
        beats = 0;
        done++;
      end
      if (done == 4) s_awvalid = 2'b00;
      @(negedge aclk); #1;
    end
    n_tests++; if (done != 4) begin n_fail++; $display("FAIL rr_done: got %0d transactions expected 4", done); end
    n_tests++; if (err_seen) begin n_fail++; $display("FAIL rr_no_err: got error pulse expected none"); end
    exp_q.delete();
    wait_state(ST_IDLE, 20, ok);
  endtask

  task automatic test_w_leads_aw();
    int beats;
    bit ok, left_addr;
    logic [0:0] e;
    clear_inputs();
    s_awlen = {8'd0, 8'd3}; s_awvalid = 2'b01;
    m_wvalid = 1'b1; m_wready = 1'b1; m_bready = 1'b1;
    exp_q.push_back(1'b0);
    wait_state(ST_ADDR, 20, ok);
    e = exp_q.pop_front();
    n_tests++; if (!ok || grant_idx !== e) begin n_fail++; $display("FAIL wlead_grant: grant_idx=%b expected %b", grant_idx, e); end
    beats = 0; left_addr = 1'b0;
    for (int c = 0; c < 10; c++) begin
      m_wlast = (beats == 3);
      #1;
      if (w_en) beats++;
      if (dbg_state != ST_ADDR) left_addr = 1'b1;
      @(negedge aclk); #1;
    end
    n_tests++; if (beats != 4) begin n_fail++; $display("FAIL wlead_beats: got %0d beats expected 4", beats); end
    n_tests++; if (left_addr || dbg_state !== ST_ADDR || w_en !== 1'b0) begin n_fail++; $display("FAIL wlead_hold_addr: state=%0d w_en=%b expected %0d/0", dbg_state, w_en, ST_ADDR); end
    m_awready = 1'b1;
    @(negedge aclk); #1;
    s_awvalid = 2'b00;
    n_tests++; if (dbg_state !== ST_RESP || aw_en !== 1'b0) begin n_fail++; $display("FAIL wlead_direct_resp: state=%0d aw_en=%b expected %0d/0", dbg_state, aw_en, ST_RESP); end
    m_bvalid = 1'b1;
    @(negedge aclk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wlead_release: busy=%b expected 0", busy); end
    clear_inputs();
  endtask

  task automatic test_wlast_mismatch(input int wlast_beat);
    int beats, comp;
    bit ok;
    logic [0:0] e;
    clear_inputs();
    comp = (wlast_beat != 0) ? wlast_beat : 4;
    for (int b = 1; b <= comp; b++) exp_q.push_back((b == comp) && ((b == wlast_beat) != (b == 4)));
    s_awlen = {8'd0, 8'd3}; s_awvalid = 2'b01;
    m_awready = 1'b1; m_wvalid = 1'b1; m_wready = 1'b1; m_bvalid = 1'b1; m_bready = 1'b1;
    wait_state(ST_ADDR, 20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL wlast_grant: state=%0d expected %0d", dbg_state, ST_ADDR); end
    beats = 0;
    for (int c = 0; c < 20; c++) begin
      m_wlast = (beats + 1 == wlast_beat);
      #1;
      if (b_en) break;
      if (w_en) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL wlast_extra_beat: beat %0d accepted, expected burst ended at %0d", beats + 1, comp);
        end else begin
          e = exp_q.pop_front();
          if (err_wlast !== e) begin n_fail++; $display("FAIL wlast_err_beat%0d: err_wlast=%b expected %b (wlast beat %0d)", beats + 1, err_wlast, e, wlast_beat); end
        end
        beats++;
      end
      if (dbg_state == ST_DATA) s_awvalid = 2'b00;
      @(negedge aclk); #1;
    end
    n_tests++; if (beats != comp || b_en !== 1'b1) begin n_fail++; $display("FAIL wlast_to_resp: beats=%0d b_en=%b expected %0d/1", beats, b_en, comp); end
    exp_q.delete();
    m_wlast = 1'b0; s_awvalid = 2'b00;
    wait_state(ST_IDLE, 20, ok);
  endtask

  task automatic test_b_timeout();
    int resp;
    bit ok, fired;
    logic [0:0] e;
    clear_inputs();
    s_awlen = 16'h0; s_awvalid = 2'b01;
    m_awready = 1'b1; m_wvalid = 1'b1; m_wready = 1'b1; m_wlast = 1'b1; m_bready = 1'b1;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1);
    wait_state(ST_ADDR, 20, ok);
    e = exp_q.pop_front();
    n_tests++; if (!ok || grant_idx !== e) begin n_fail++; $display("FAIL tmo_first_grant: grant_idx=%b expected %b", grant_idx, e); end
    @(negedge aclk); #1;
    s_awvalid = 2'b10; m_wvalid = 1'b0;
    n_tests++; if (dbg_state !== ST_RESP) begin n_fail++; $display("FAIL tmo_aw_w_same_cycle: state=%0d expected %0d", dbg_state, ST_RESP); end
    resp = 0; fired = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (b_en) resp++;
      if (err_timeout) begin
        fired = 1'b1;
        break;
      end
      @(negedge aclk); #1;
    end
    n_tests++; if (!fired || resp != 16) begin n_fail++; $display("FAIL tmo_cycle: fired=%b at resp cycle %0d expected 1 at 16", fired, resp); end
    @(negedge aclk); #1;
    n_tests++; if (busy !== 1'b0 || grant_oh !== 2'b00 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_release: busy=%b grant_oh=%b err_timeout=%b expected 0/00/0", busy, grant_oh, err_timeout); end
    wait_state(ST_ADDR, 20, ok);
    e = exp_q.pop_front();
    n_tests++; if (!ok || grant_idx !== e || grant_oh !== (2'b01 << e)) begin n_fail++; $display("FAIL tmo_next_grant: grant_idx=%b grant_oh=%b expected %b/%b", grant_idx, grant_oh, e, 2'b01 << e); end
    m_wvalid = 1'b1; m_bvalid = 1'b1;
    @(negedge aclk); #1;
    s_awvalid = 2'b00;
    wait_state(ST_IDLE, 20, ok);
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [0:0] e;
    clear_inputs();
    s_awlen = 16'h0; s_awvalid = 2'b01;
    m_awready = 1'b1; m_wvalid = 1'b1; m_wready = 1'b1; m_wlast = 1'b1; m_bvalid = 1'b1; m_bready = 1'b1;
    wait_state(ST_ADDR, 20, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL b2b_first_grant: state=%0d expected %0d", dbg_state, ST_ADDR); end
    for (int k = 0; k < 8; k++) exp_q.push_back((k % 3) != 2);
    for (int c = 0; c < 8; c++) begin
      e = exp_q.pop_front();
      n_tests++; if (busy !== e) begin n_fail++; $display("FAIL b2b_busy: cycle %0d busy=%b expected %b", c, busy, e); end
      if (c % 3 == 0) begin
        n_tests++; if (grant_oh !== 2'b01 || dbg_state !== ST_ADDR) begin n_fail++; $display("FAIL b2b_grant: cycle %0d grant_oh=%b state=%0d expected 01/%0d", c, grant_oh, dbg_state, ST_ADDR); end
      end
      if (c == 7) s_awvalid = 2'b00;
      @(negedge aclk); #1;
    end
    n_tests++; if (busy !== 1'b0 || err_wlast !== 1'b0) begin n_fail++; $display("FAIL b2b_end_idle: busy=%b err_wlast=%b expected 0/0", busy, err_wlast); end
    clear_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    areset = 1'b1;
    clear_inputs();
    test_reset();
    test_reset_mid_data();
    test_rr_fairness();
    test_w_leads_aw();
    test_wlast_mismatch(2);
    test_wlast_mismatch(0);
    test_b_timeout();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
